load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage front end for the vectorStorage data memory. It sits directly upstream of the storage and drives its MemEn, WriteEnable, ByteEn, MemoryAdress and InputData.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) through a valid/ready handshake. Produces byte enables and lane-aligned store data, then sign- or zero-extends load data.
- Splits misaligned accesses into two aligned word beats and stalls the request side while doing so.

Parameters:
- MEMORY_SIZE_BITS, 1024: total storage size in bits. Must be a multiple of 32.
- ADRESS_SIZE, 10: width of the storage bit-index port. Must satisfy 2^ADRESS_SIZE >= MEMORY_SIZE_BITS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  request accepted this cycle when ReqValid && ReqReady.
- ReqWrite  in  1  1 = store, 0 = load.
- Funct3  in  3  RV32I width/sign code.
- Adress  in  32  byte address.
- StoreData  in  32  unaligned store data; LSBs are significant.
- RespValid  out  1  one-cycle completion pulse, for both loads and stores.
- LoadData  out  32  extended load result, valid with RespValid.
- MemEn  out  1  to storage.
- WriteEnable  out  1  to storage.
- ByteEn  out  4  to storage; bit i covers lane bits [8i+7:8i].
- MemoryAdress  out  ADRESS_SIZE  storage bit index = aligned word byte address x 8.
- InputData  out  32  lane-aligned store data.
- MemData  in  32  combinational read data from storage.

Behaviour:
- Reset, applied synchronously while reset=1:
  - state=IDLE.
  - RespValid=0, LoadData=0.
  - MemEn=0, WriteEnable=0, ByteEn=0.
  - ReqReady=0 during reset, 1 afterwards in IDLE.
- Address handling:
  - Byte offset is Adress[1:0]; word index is Adress[31:2] modulo MEMORY_SIZE_BITS/32.
  - Bits above the storage size are ignored. Word index wraps, so the second beat after the last word goes to word 0.
- Little-endian: byte at offset k maps to lane k.
- Size comes from Funct3[1:0]: 00 byte, 01 half, 10 word; 11 is illegal.
- Misaligned cases: half with offset 3; word with offset 1, 2 or 3.
- Aligned access (IDLE, handshake in cycle N):
  - Storage driven combinationally in cycle N: MemEn=1, WriteEnable=ReqWrite, ByteEn=size mask << offset, InputData=StoreData << 8*offset.
  - MemData is shifted, extended and registered.
  - RespValid=1 in cycle N+1.
- Misaligned access (handshake in cycle N):
  - Beat 0 in cycle N: word W, lanes offset..3.
  - Go to SECOND and latch request fields; ReqReady=0 in SECOND.
  - Beat 1 in cycle N+1: word W+1, lanes 0..(offset+size-5). Store bytes continue in order.
  - Load result = beat-0 upper lanes (registered) concatenated with beat-1 lower lanes, then extended.
  - RespValid=1 in cycle N+2; return to IDLE in N+1, so a new request can be accepted in N+2.
- FSM states: IDLE and SECOND.
  - IDLE goes to SECOND on a misaligned handshake.
  - SECOND always goes to IDLE after one cycle.
- Extension: Funct3[2]=1 (LBU/LHU) zero-extends. Otherwise sign-extends from bit 7 or 15. LW passes through unchanged.
- Illegal Funct3 (size 11):
  - Request is accepted and MemEn=0.
  - RespValid pulses with LoadData=0.
- Idle behaviour: MemEn=0 whenever there is no handshake and state is not SECOND.
- Reset in SECOND: beat 1 is not issued, no RespValid, state returns to IDLE.
- Back-to-back aligned requests sustain one per cycle.

Optional Feature:
- Macro: LSU_MISALIGNED_TRAP_EN.
- Defined:
  - Adds output MisalignedFault (1 bit). It pulses in cycle N+1 together with RespValid for a misaligned request.
  - No storage access occurs (MemEn=0), LoadData=0, and the SECOND state is never entered.
- Undefined: misaligned accesses are split as above and MisalignedFault does not exist.

Decomposition:
- Shared package lsu_pkg:
  - Funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use the same low bits).
  - Size enum and state enum {IDLE, SECOND}.
  - WORD_BYTES=4.
- Sub-module lsu_lane_extend (combinational): takes assembled 32-bit raw data, size and unsigned flag, and returns the extended word. Used for the final load result.

Test Plan:
- Memory word 0 = 0x8899AABB. LB at Adress 0x1 -> ByteEn=0010 in cycle N, RespValid in N+1, LoadData=0xFFFFFFAA. LBU at 0x1 -> 0x000000AA.
- SH of 0x1234 at 0x2 -> ByteEn=1100, InputData=0x12340000, WriteEnable=1. A subsequent LW at 0x0 returns 0x1234AABB.
- Word 0 = 0x44332211, word 1 = 0x88776655. LW at 0x3 -> beat 0 ByteEn=1000 at word 0, beat 1 ByteEn=0111 at word 1, ReqReady=0 in N+1, RespValid in N+2, LoadData=0x77665544.
- SW of 0xDDCCBBAA at the last word address + 2 -> beat 1 writes lanes 0..1 of word 0 with 0xDDCC (wrap-around).
- Assert reset while in SECOND -> no beat-1 MemEn, no RespValid, ReqReady=1 in the first cycle after reset deasserts.
- With LSU_MISALIGNED_TRAP_EN defined, LH at 0x3 -> MemEn=0, MisalignedFault=1 and RespValid=1 in N+1, LoadData=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, access
// size and FSM state enums, and the latched second-beat record.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_e;

  // Everything beat 1 of a split access needs, captured at the beat-0 handshake.
  typedef struct packed {
    logic [1:0]  off;
    lsu_size_e   size;
    logic        uns;
    logic        write;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] lo;
  } lsu_pend_t;

  function automatic logic [3:0] size_mask(input lsu_size_e size);
    case (size)
      SIZE_BYTE: size_mask = 4'b0001;
      SIZE_HALF: size_mask = 4'b0011;
      SIZE_WORD: size_mask = 4'b1111;
      default:   size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    is_misaligned = ((size == SIZE_HALF) && (off == 2'd3)) ||
                    ((size == SIZE_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_extend.sv
// Sign/zero extension of an assembled, lane-0-aligned load value.
module lsu_lane_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
      SIZE_HALF: ext_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for the vectorStorage memory; splits misaligned
// accesses into two word beats. LSU_MISALIGNED_TRAP_EN faults them instead.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE_BITS = 1024,
  parameter int ADRESS_SIZE      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [2:0]             Funct3,
  input  logic [31:0]            Adress,
  input  logic [31:0]            StoreData,
  output logic                   RespValid,
  output logic [31:0]            LoadData,
  output logic                   MemEn,
  output logic                   WriteEnable,
  output logic [3:0]             ByteEn,
  output logic [ADRESS_SIZE-1:0] MemoryAdress,
  output logic [31:0]            InputData,
  input  logic [31:0]            MemData
`ifdef LSU_MISALIGNED_TRAP_EN
  ,
  output logic                   MisalignedFault
`endif
);

  localparam int NUM_WORDS = MEMORY_SIZE_BITS / 32;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  lsu_state_e        state_q, state_d;
  lsu_pend_t         pend_q, pend_d;
  logic [WIDX_W-1:0] widx1_q;
  logic              resp_q, resp_d;
  logic [31:0]       load_q, load_d;
  logic              split_start;

  lsu_size_e         req_size;
  logic [1:0]        req_off;
  logic              req_illegal, req_mis, handshake;
  logic [WIDX_W-1:0] req_widx, req_widx_next, word_sel;
  logic [7:0]        be_wide;
  logic [63:0]       data_wide;
  logic [31:0]       aligned_raw, split_raw;

  logic [31:0]       ext_raw, ext_out;
  lsu_size_e         ext_size;
  logic              ext_uns;

  assign req_size    = lsu_size_e'(Funct3[1:0]);
  assign req_off     = Adress[1:0];
  assign req_illegal = (req_size == SIZE_ILLEGAL);
  assign req_mis     = is_misaligned(req_size, req_off);
  assign ReqReady    = !reset && (state_q == IDLE);
  assign handshake   = ReqValid && ReqReady;

  // Word index wraps at the storage size; address bits above it are dropped.
  assign req_widx      = WIDX_W'(Adress[31:2] % 30'(NUM_WORDS));
  assign req_widx_next = (req_widx == WIDX_W'(NUM_WORDS - 1)) ? '0 : req_widx + WIDX_W'(1);

  // Shifting into a double-width window gives beat 0 in the low half and
  // the spill-over lanes for beat 1 in the high half.
  assign be_wide   = {4'b0000, size_mask(req_size)} << req_off;
  assign data_wide = {32'b0, StoreData} << {req_off, 3'b000};

  assign aligned_raw = MemData >> {req_off, 3'b000};
  assign split_raw   = 32'({MemData, pend_q.lo} >> {pend_q.off, 3'b000});

  assign pend_d.off   = req_off;
  assign pend_d.size  = req_size;
  assign pend_d.uns   = Funct3[2];
  assign pend_d.write = ReqWrite;
  assign pend_d.be    = be_wide[7:4];
  assign pend_d.data  = data_wide[63:32];
  assign pend_d.lo    = MemData;

  assign MemoryAdress = ADRESS_SIZE'({word_sel, 5'b00000});
  assign RespValid    = resp_q;
  assign LoadData     = load_q;

  lsu_lane_extend u_ext (
    .raw_i      (ext_raw),
    .size_i     (ext_size),
    .unsigned_i (ext_uns),
    .ext_o      (ext_out)
  );

`ifdef LSU_MISALIGNED_TRAP_EN
  logic fault_q, fault_d;
  assign MisalignedFault = fault_q;
`endif

  always_comb begin
    state_d     = state_q;
    resp_d      = 1'b0;
    load_d      = load_q;
    split_start = 1'b0;
    MemEn       = 1'b0;
    WriteEnable = 1'b0;
    ByteEn      = 4'b0000;
    word_sel    = req_widx;
    InputData   = data_wide[31:0];
    ext_raw     = aligned_raw;
    ext_size    = req_size;
    ext_uns     = Funct3[2];
`ifdef LSU_MISALIGNED_TRAP_EN
    fault_d     = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            resp_d = 1'b1;
            if (req_illegal) begin
              load_d = 32'h0;
            end else if (req_mis) begin
`ifdef LSU_MISALIGNED_TRAP_EN
              load_d  = 32'h0;
              fault_d = 1'b1;
`else
              MemEn       = 1'b1;
              WriteEnable = ReqWrite;
              ByteEn      = be_wide[3:0];
              resp_d      = 1'b0;
              split_start = 1'b1;
              state_d     = SECOND;
`endif
            end else begin
              MemEn       = 1'b1;
              WriteEnable = ReqWrite;
              ByteEn      = be_wide[3:0];
              load_d      = ReqWrite ? 32'h0 : ext_out;
            end
          end
        end
        SECOND: begin
          state_d     = IDLE;
          MemEn       = 1'b1;
          WriteEnable = pend_q.write;
          ByteEn      = pend_q.be;
          word_sel    = widx1_q;
          InputData   = pend_q.data;
          ext_raw     = split_raw;
          ext_size    = pend_q.size;
          ext_uns     = pend_q.uns;
          resp_d      = 1'b1;
          load_d      = pend_q.write ? 32'h0 : ext_out;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      load_q  <= 32'h0;
      pend_q  <= '0;
      widx1_q <= '0;
`ifdef LSU_MISALIGNED_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      load_q  <= load_d;
`ifdef LSU_MISALIGNED_TRAP_EN
      fault_q <= fault_d;
`endif
      if (split_start) begin
        pend_q  <= pend_d;
        widx1_q <= req_widx_next;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled word memory model.
module tb_load_store_unit;

  localparam int MEM_BITS = 1024;
  localparam int AW       = 10;

  logic          clk;
  logic          reset;
  logic          ReqValid, ReqReady, ReqWrite;
  logic [2:0]    Funct3;
  logic [31:0]   Adress, StoreData;
  logic          RespValid;
  logic [31:0]   LoadData;
  logic          MemEn, WriteEnable;
  logic [3:0]    ByteEn;
  logic [AW-1:0] MemoryAdress;
  logic [31:0]   InputData, MemData;
`ifdef LSU_MISALIGNED_TRAP_EN
  logic          MisalignedFault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [MEM_BITS/32];

  load_store_unit #(.MEMORY_SIZE_BITS(MEM_BITS), .ADRESS_SIZE(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .Funct3       (Funct3),
    .Adress       (Adress),
    .StoreData    (StoreData),
    .RespValid    (RespValid),
    .LoadData     (LoadData),
    .MemEn        (MemEn),
    .WriteEnable  (WriteEnable),
    .ByteEn       (ByteEn),
    .MemoryAdress (MemoryAdress),
    .InputData    (InputData),
    .MemData      (MemData)
`ifdef LSU_MISALIGNED_TRAP_EN
    ,
    .MisalignedFault (MisalignedFault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemData = mem[MemoryAdress[AW-1:5]];

  always @(posedge clk) begin
    if (MemEn && WriteEnable) begin
      for (int i = 0; i < 4; i++) begin
        if (ByteEn[i]) mem[MemoryAdress[AW-1:5]][8*i +: 8] <= InputData[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string name, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    ReqValid  = 1'b1;
    ReqWrite  = w;
    Funct3    = f3;
    Adress    = a;
    StoreData = sd;
    $display("txn %-12s we=%0b f3=%03b addr=0x%08h sdata=0x%08h", name, w, f3, a, sd);
  endtask

  task automatic go_idle();
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    Funct3    = 3'b000;
    Adress    = 32'h0;
    StoreData = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    go_idle();
    for (int i = 0; i < MEM_BITS/32; i++) mem[i] <= 32'h0;
    next_cycle();
    @(negedge clk);
    check("rst_ready", 32'(ReqReady), 32'h0);
    check("rst_memen", 32'(MemEn), 32'h0);
    check("rst_be",    32'(ByteEn), 32'h0);
    check("rst_resp",  32'(RespValid), 32'h0);
    check("rst_load",  LoadData, 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ReqReady), 32'h1);
    check("idle_memen",      32'(MemEn), 32'h0);
    next_cycle();

    // Byte loads, back to back
    mem[0] <= 32'h8899AABB;
    drive("LB 0x1", 1'b0, 3'b000, 32'h1, 32'h0);
    @(negedge clk);
    check("lb_be",    32'(ByteEn), 32'h2);
    check("lb_memen", 32'(MemEn), 32'h1);
    check("lb_we",    32'(WriteEnable), 32'h0);
    check("lb_addr",  32'(MemoryAdress), 32'h0);
    next_cycle();
    check("lb_resp",  32'(RespValid), 32'h1);
    check("lb_data",  LoadData, 32'hFFFFFFAA);
    drive("LBU 0x1", 1'b0, 3'b100, 32'h1, 32'h0);
    next_cycle();
    check("lbu_resp", 32'(RespValid), 32'h1);
    check("lbu_data", LoadData, 32'h000000AA);
    go_idle();
    next_cycle();
    check("idle_resp", 32'(RespValid), 32'h0);

    // Half store then word load
    drive("SH 0x2", 1'b1, 3'b001, 32'h2, 32'h00001234);
    @(negedge clk);
    check("sh_be",    32'(ByteEn), 32'hC);
    check("sh_wdata", InputData, 32'h12340000);
    check("sh_we",    32'(WriteEnable), 32'h1);
    next_cycle();
    go_idle();
    check("sh_resp",  32'(RespValid), 32'h1);
    check("sh_mem0",  mem[0], 32'h1234AABB);
    drive("LW 0x0", 1'b0, 3'b010, 32'h0, 32'h0);
    next_cycle();
    check("lw_data",  LoadData, 32'h1234AABB);

    // Illegal size: accepted, no storage access, zero result
    drive("ILL 0x0", 1'b0, 3'b011, 32'h0, 32'h0);
    @(negedge clk);
    check("ill_memen", 32'(MemEn), 32'h0);
    next_cycle();
    go_idle();
    check("ill_resp", 32'(RespValid), 32'h1);
    check("ill_data", LoadData, 32'h0);
    next_cycle();

`ifndef LSU_MISALIGNED_TRAP_EN
    // Misaligned word load split across words 0 and 1
    mem[0] <= 32'h44332211;
    mem[1] <= 32'h88776655;
    drive("LW 0x3", 1'b0, 3'b010, 32'h3, 32'h0);
    @(negedge clk);
    check("mlw_b0_be",   32'(ByteEn), 32'h8);
    check("mlw_b0_addr", 32'(MemoryAdress), 32'h0);
    next_cycle();
    go_idle();
    check("mlw_n1_resp", 32'(RespValid), 32'h0);
    @(negedge clk);
    check("mlw_n1_ready", 32'(ReqReady), 32'h0);
    check("mlw_b1_memen", 32'(MemEn), 32'h1);
    check("mlw_b1_be",    32'(ByteEn), 32'h7);
    check("mlw_b1_addr",  32'(MemoryAdress), 32'd32);
    next_cycle();
    check("mlw_resp",  32'(RespValid), 32'h1);
    check("mlw_data",  LoadData, 32'h77665544);
    @(negedge clk);
    check("mlw_ready", 32'(ReqReady), 32'h1);
    next_cycle();

    // Halfword sign/zero extension from bit 15
    drive("LH 0x6", 1'b0, 3'b001, 32'h6, 32'h0);
    next_cycle();
    check("lh_data", LoadData, 32'hFFFF8877);
    drive("LHU 0x6", 1'b0, 3'b101, 32'h6, 32'h0);
    next_cycle();
    check("lhu_data", LoadData, 32'h00008877);
    go_idle();

    // Misaligned store at the last word wraps to word 0; high address bits ignored
    drive("SW 0x..7E", 1'b1, 3'b010, 32'h1000007E, 32'hDDCCBBAA);
    @(negedge clk);
    check("msw_b0_be",    32'(ByteEn), 32'hC);
    check("msw_b0_wdata", InputData, 32'hBBAA0000);
    check("msw_b0_addr",  32'(MemoryAdress), 32'd992);
    next_cycle();
    go_idle();
    @(negedge clk);
    check("msw_b1_be",    32'(ByteEn), 32'h3);
    check("msw_b1_wdata", InputData, 32'h0000DDCC);
    check("msw_b1_addr",  32'(MemoryAdress), 32'h0);
    next_cycle();
    check("msw_resp",  32'(RespValid), 32'h1);
    check("msw_mem31", mem[31], 32'hBBAA0000);
    check("msw_mem0",  mem[0], 32'h4433DDCC);

    // Reset while in SECOND
    drive("LW 0x1 rst", 1'b0, 3'b010, 32'h1, 32'h0);
    next_cycle();
    go_idle();
    reset = 1'b1;
    @(negedge clk);
    check("rsec_memen", 32'(MemEn), 32'h0);
    check("rsec_ready", 32'(ReqReady), 32'h0);
    next_cycle();
    check("rsec_resp", 32'(RespValid), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rsec_ready_after", 32'(ReqReady), 32'h1);
    check("rsec_resp_after",  32'(RespValid), 32'h0);
    next_cycle();
`else
    // Misaligned access faults with no storage access
    drive("LH 0x3 trap", 1'b0, 3'b001, 32'h3, 32'h0);
    @(negedge clk);
    check("trap_memen", 32'(MemEn), 32'h0);
    next_cycle();
    go_idle();
    check("trap_resp",  32'(RespValid), 32'h1);
    check("trap_fault", 32'(MisalignedFault), 32'h1);
    check("trap_data",  LoadData, 32'h0);
    @(negedge clk);
    check("trap_ready", 32'(ReqReady), 32'h1);
    next_cycle();
    check("trap_fault_clear", 32'(MisalignedFault), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
